// File: rtl/soc_test_monitor_pkg.sv
// +--------------------------------------------------------------------------+
// | soc_test_pkg: shared states and address map of the SoC test monitor       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package soc_test_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_HOLD    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN     = 3'd1;
  localparam logic [STATE_W-1:0] ST_PASS    = 3'd2;
  localparam logic [STATE_W-1:0] ST_FAIL    = 3'd3;
  localparam logic [STATE_W-1:0] ST_TIMEOUT = 3'd4;

  localparam logic [31:0] TOHOST_PASS = 32'd1;

  // Must agree with the linker script of the compliance programs
  localparam logic [31:0] TOHOST_ADDR_DFLT = 32'h8000_1000;
  localparam logic [31:0] SIG_BASE_DFLT    = 32'h8000_2000;
  localparam int          SIG_WORDS_DFLT   = 64;

endpackage

`default_nettype wire

// File: rtl/soc_test_monitor_if.sv
// +--------------------------------------------------------------------------+
// | soc_test_monitor_if: data-memory write port observed by the monitor      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface soc_test_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

`default_nettype wire

// File: rtl/soc_test_monitor_sig_accum.sv
// +--------------------------------------------------------------------------+
// | soc_sig_accum: signature-region decode, rotate-xor sum, write counter    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module soc_sig_accum
  import soc_test_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SIG_BASE  = ADDR_W'(SIG_BASE_DFLT),
  parameter int                SIG_WORDS = SIG_WORDS_DFLT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              en,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  output logic      [15:0]       sig_count,
  output logic      [DATA_W-1:0] sig_sum
);

  localparam logic [ADDR_W:0] c_span = (ADDR_W+1)'(SIG_WORDS) << 2;

  logic [ADDR_W-1:0] w_off;
  logic              w_hit;
  logic [15:0]       sig_count_d, sig_count_q;
  logic [DATA_W-1:0] sig_sum_d, sig_sum_q;

  // Offset compare avoids overflow of SIG_BASE + span near the top of memory
  assign w_off = wr_addr - SIG_BASE;
  assign w_hit = (wr_addr >= SIG_BASE) && ({1'b0, w_off} < c_span);

  always_comb begin
    sig_count_d = sig_count_q;
    sig_sum_d   = sig_sum_q;
    if (en && wr_en && w_hit) begin
      sig_sum_d = {sig_sum_q[DATA_W-2:0], sig_sum_q[DATA_W-1]} ^ wr_data;
      if (sig_count_q != 16'hFFFF) begin
        sig_count_d = sig_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_count_q <= '0;
      sig_sum_q   <= '0;
    end else begin
      sig_count_q <= sig_count_d;
      sig_sum_q   <= sig_sum_d;
    end
  end

  assign sig_count = sig_count_q;
  assign sig_sum   = sig_sum_q;

endmodule

`default_nettype wire

// File: rtl/soc_test_monitor.sv
// +--------------------------------------------------------------------------+
// | soc_test_monitor: SoC reset sequencer, tohost/signature monitor, watchdog|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module soc_test_monitor
  import soc_test_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                RST_CYCLES  = 2,
  parameter int                TIMEOUT     = 150,
  parameter int                CNT_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DFLT),
  parameter logic [ADDR_W-1:0] SIG_BASE    = ADDR_W'(SIG_BASE_DFLT),
  parameter int                SIG_WORDS   = SIG_WORDS_DFLT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  soc_test_monitor_if.slave      bus,
  output logic                   core_rst,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic      [DATA_W-2:0] fail_code,
  output logic      [CNT_W-1:0]  cycles,
  output logic      [15:0]       sig_count,
  output logic      [DATA_W-1:0] sig_sum
);

  localparam int                HOLD_W       = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] c_hold_last  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_wdog_last  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   c_span       = (ADDR_W+1)'(SIG_WORDS) << 2;
  localparam logic [ADDR_W-1:0] c_tohost_off = TOHOST_ADDR - SIG_BASE;

  if ((TOHOST_ADDR >= SIG_BASE) && ({1'b0, c_tohost_off} < c_span)) begin : g_tohost_in_sig
    $fatal(1, "soc_test_monitor: TOHOST_ADDR lies inside the signature region");
  end
  if ((RST_CYCLES < 1) || (TIMEOUT < 1)) begin : g_bad_counts
    $fatal(1, "soc_test_monitor: RST_CYCLES and TIMEOUT must be at least 1");
  end

  logic [STATE_W-1:0] state_d, state_q;
  logic [HOLD_W-1:0]  hold_d, hold_q;
  logic [CNT_W-1:0]   cycles_d, cycles_q;
  logic [DATA_W-2:0]  fail_code_d, fail_code_q;
  logic               core_rst_d, core_rst_q;
  logic               done_d, done_q;
  logic               pass_d, pass_q;
  logic               timeout_d, timeout_q;
  logic               w_tohost_wr;

  assign w_tohost_wr = bus.wr_en && (bus.wr_addr == TOHOST_ADDR);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cycles_d    = cycles_q;
    fail_code_d = fail_code_q;
    core_rst_d  = core_rst_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == c_hold_last) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycles_d = cycles_q + CNT_W'(1);
        // A tohost write outranks watchdog expiry in the same cycle
        if (w_tohost_wr && (bus.wr_data == DATA_W'(TOHOST_PASS))) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (w_tohost_wr && bus.wr_data[0]) begin
          state_d     = ST_FAIL;
          done_d      = 1'b1;
          fail_code_d = bus.wr_data[DATA_W-1:1];
        end else if (cycles_q == c_wdog_last) begin
          state_d   = ST_TIMEOUT;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      cycles_q    <= '0;
      fail_code_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycles_q    <= cycles_d;
      fail_code_q <= fail_code_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  soc_sig_accum #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SIG_BASE  (SIG_BASE),
    .SIG_WORDS (SIG_WORDS)
  ) u_sig_accum (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_RUN),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .sig_count (sig_count),
    .sig_sum   (sig_sum)
  );

  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_code = fail_code_q;
  assign cycles    = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_test_monitor.sv
// +--------------------------------------------------------------------------+
// | tb_soc_test_monitor: directed self-checking bench for soc_test_monitor   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_soc_test_monitor;

  localparam logic [31:0] c_tohost = 32'h8000_1000;
  localparam logic [31:0] c_sig    = 32'h8000_2000;

  logic        clk;
  logic        rst;
  logic        core_rst;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] fail_code;
  logic [31:0] cycles;
  logic [15:0] sig_count;
  logic [31:0] sig_sum;

  int n_pass  = 0;
  int n_total = 0;

  soc_test_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  soc_test_monitor #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .RST_CYCLES  (2),
    .TIMEOUT     (150),
    .CNT_W       (32),
    .TOHOST_ADDR (c_tohost),
    .SIG_BASE    (c_sig),
    .SIG_WORDS   (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .fail_code (fail_code),
    .cycles    (cycles),
    .sig_count (sig_count),
    .sig_sum   (sig_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "bench watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Asynchronous reset pulse, then release and step through the two HOLD edges
  task automatic restart();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    idle(2);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_sig_sum", sig_sum, 0);

    // Release with a signature write held active through HOLD
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = c_sig;
    bus.wr_data = 32'hFFFF_FFFF;
    tick();
    chk("hold_edge1_core_rst", core_rst, 1);
    chk("hold_edge1_sig_count", sig_count, 0);
    tick();
    bus.wr_en = 1'b0;
    chk("hold_edge2_core_rst", core_rst, 0);
    chk("hold_edge2_sig_count", sig_count, 0);
    chk("hold_edge2_cycles", cycles, 0);

    // Signature accumulation and region bounds
    wr(c_sig, 32'hA5A5_0000);
    chk("sig1_count", sig_count, 1);
    chk("sig1_sum", sig_sum, 32'hA5A5_0000);
    wr(c_sig + 32'd252, 32'h0000_00FF);
    chk("sig2_count", sig_count, 2);
    chk("sig2_sum", sig_sum, 32'h4B4A_00FE);
    wr(c_sig + 32'd256, 32'h1234_5678);
    wr(c_sig - 32'd4, 32'h1234_5678);
    chk("sig_oob_count", sig_count, 2);
    chk("sig_oob_sum", sig_sum, 32'h4B4A_00FE);

    // Even tohost data is console traffic, odd data != 1 fails
    wr(c_tohost, 32'h4);
    chk("even_done", done, 0);
    chk("even_cycles", cycles, 5);
    wr(c_tohost, 32'h7);
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_timeout", timeout, 0);
    chk("fail_code", fail_code, 3);
    chk("fail_cycles", cycles, 6);
    wr(c_sig, 32'h0000_0001);
    wr(c_tohost, 32'h1);
    idle(3);
    chk("fail_frozen_pass", pass, 0);
    chk("fail_frozen_sig", sig_count, 2);
    chk("fail_frozen_cycles", cycles, 6);
    chk("fail_frozen_core_rst", core_rst, 0);

    // PASS on RUN cycle 40
    restart();
    chk("run2_core_rst", core_rst, 0);
    chk("run2_cycles", cycles, 0);
    idle(40);
    chk("pre_pass_done", done, 0);
    wr(c_tohost, 32'h1);
    chk("pass_done", done, 1);
    chk("pass_pass", pass, 1);
    chk("pass_cycles", cycles, 41);
    idle(200);
    chk("pass_frozen_cycles", cycles, 41);
    chk("pass_frozen_timeout", timeout, 0);
    chk("pass_frozen_fail_code", fail_code, 0);

    // Watchdog expiry
    restart();
    idle(149);
    chk("wdog_149_timeout", timeout, 0);
    chk("wdog_149_cycles", cycles, 149);
    tick();
    chk("wdog_timeout", timeout, 1);
    chk("wdog_done", done, 1);
    chk("wdog_pass", pass, 0);
    chk("wdog_cycles", cycles, 150);
    idle(5);
    chk("wdog_frozen_cycles", cycles, 150);

    // tohost pass on the expiry cycle wins over the watchdog
    restart();
    idle(149);
    wr(c_tohost, 32'h1);
    chk("race_pass", pass, 1);
    chk("race_timeout", timeout, 0);
    chk("race_cycles", cycles, 150);

    // Asynchronous reset in the middle of RUN
    restart();
    wr(c_sig, 32'hDEAD_BEEF);
    idle(10);
    chk("mid_sig_sum", sig_sum, 32'hDEAD_BEEF);
    #2 rst = 1'b0;
    #1;
    chk("async_core_rst", core_rst, 1);
    chk("async_cycles", cycles, 0);
    chk("async_sig_count", sig_count, 0);
    chk("async_sig_sum", sig_sum, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rehold_edge1_core_rst", core_rst, 1);
    tick();
    chk("rehold_edge2_core_rst", core_rst, 0);
    idle(3);
    chk("rehold_cycles", cycles, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
